// File: rtl/mod_bit_arbiter.sv
// rtl/mod_bit_arbiter.sv - round-robin owner arbiter in front of the shared mod_bit command engine
// Optional stuck-owner revocation is enabled by defining MOD_BIT_ARB_TIMEOUT_EN.

`ifndef MOD_BIT_CMD_WIDTH
`define MOD_BIT_CMD_WIDTH 3
`endif
`ifndef MOD_BIT_CMD_NOP_
`define MOD_BIT_CMD_NOP_ 4'h0
`endif

module mod_bit_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset_n,
  input  logic                                     i_clk_quarter,
  input  logic [N_REQ-1:0]                         i_req,
  input  logic [N_REQ*(`MOD_BIT_CMD_WIDTH+1)-1:0]  i_cmd,
  output logic [N_REQ-1:0]                         o_gnt,
  output logic [N_REQ-1:0]                         o_cmd_tick,
  output logic [`MOD_BIT_CMD_WIDTH:0]              o_cmd,
  input  logic                                     i_cmd_tick,
  output logic                                     o_busy,
  output logic                                     o_timeout
);

  localparam int CMD_W = `MOD_BIT_CMD_WIDTH + 1;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CMD_W-1:0] CMD_NOP = `MOD_BIT_CMD_NOP_;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] last_nxt;
  logic [N_REQ-1:0] eff_req;
  logic [N_REQ-1:0] req_rot;
  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic             revoke;

`ifdef MOD_BIT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_mask;
  logic             r_timeout;

  assign revoke    = (r_state == ST_OWNED) && (r_cnt == CNT_W'(TIMEOUT));
  assign eff_req   = i_req & ~r_mask;
  assign o_timeout = r_timeout;

  // A revoked owner stays masked until it lets go of its request.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt     <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= revoke;
      r_mask    <= (r_mask & i_req) | (revoke ? r_gnt : '0);
      if (r_state != ST_OWNED || i_cmd_tick) begin
        r_cnt <= '0;
      end else if (i_clk_quarter && !revoke) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_cfg;

  assign revoke     = 1'b0;
  assign eff_req    = i_req;
  assign o_timeout  = 1'b0;
  assign unused_cfg = i_clk_quarter ^ (TIMEOUT > 0);
`endif

  // Rotate so bit 0 is the requester just after the last owner; lowest set bit wins.
  always_comb begin
    req_rot = N_REQ'({eff_req, eff_req} >> (int'(r_last) + 1));
    any_req = |req_rot;
    pick    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick = IDX_W'((int'(r_last) + 1 + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = r_state;
    gnt_nxt   = r_gnt;
    last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (any_req) begin
          gnt_nxt   = N_REQ'(1) << pick;
          last_nxt  = pick;
          state_nxt = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (revoke || !(|(i_req & r_gnt))) begin
          gnt_nxt   = '0;
          state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        gnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
    end else begin
      r_state <= state_nxt;
      r_gnt   <= gnt_nxt;
      r_last  <= last_nxt;
    end
  end

  // Only the registered owner's slice can reach mod_bit; no owner means NOP.
  always_comb begin
    o_cmd = CMD_NOP;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gnt[k]) begin
        o_cmd = i_cmd[k*CMD_W +: CMD_W];
      end
    end
  end

  assign o_gnt      = r_gnt;
  assign o_cmd_tick = {N_REQ{i_cmd_tick}} & r_gnt;
  assign o_busy     = |r_gnt;

endmodule

// File: tb/tb_mod_bit_arbiter.sv
// tb/tb_mod_bit_arbiter.sv - scoreboard bench for mod_bit_arbiter with directed vectors

module tb_mod_bit_arbiter;

  localparam logic [3:0] NOP = 4'h0;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_clk_quarter;
  logic [1:0] i_req;
  logic [7:0] i_cmd;
  logic [1:0] o_gnt;
  logic [1:0] o_cmd_tick;
  logic [3:0] o_cmd;
  logic       i_cmd_tick;
  logic       o_busy;
  logic       o_timeout;

  typedef struct packed {
    logic [1:0] gnt;
    logic [3:0] cmd;
    logic [1:0] tick;
    logic       busy;
    logic       tmo;
    logic [7:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  mod_bit_arbiter #(
    .N_REQ  (2),
    .TIMEOUT(8)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clk_quarter(i_clk_quarter),
    .i_req        (i_req),
    .i_cmd        (i_cmd),
    .o_gnt        (o_gnt),
    .o_cmd_tick   (o_cmd_tick),
    .o_cmd        (o_cmd),
    .i_cmd_tick   (i_cmd_tick),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  initial begin : monitor
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_run++;
        if ({o_gnt, o_cmd, o_cmd_tick, o_busy, o_timeout} !==
            {e.gnt, e.cmd, e.tick, e.busy, e.tmo}) begin
          n_fail++;
          $display("FAIL step%0d: got gnt=%b cmd=%h tick=%b busy=%b tmo=%b, want gnt=%b cmd=%h tick=%b busy=%b tmo=%b",
                   e.tag, o_gnt, o_cmd, o_cmd_tick, o_busy, o_timeout,
                   e.gnt, e.cmd, e.tick, e.busy, e.tmo);
        end
      end
    end
  end

  task automatic cyc(input logic rst_n, input logic [1:0] req, input logic tick,
                     input logic qtr, input logic [1:0] egnt, input logic [3:0] ecmd,
                     input logic [1:0] etick, input logic etmo, input int tag);
    exp_t x;
    i_reset_n     = rst_n;
    i_req         = req;
    i_cmd_tick    = tick;
    i_clk_quarter = qtr;
    x.gnt  = egnt;
    x.cmd  = ecmd;
    x.tick = etick;
    x.busy = |egnt;
    x.tmo  = etmo;
    x.tag  = 8'(tag);
    exp_q.push_back(x);
    @(posedge i_clk);
    #1;
  endtask

  initial begin : stimulus
    i_reset_n     = 1'b0;
    i_req         = 2'b00;
    i_cmd_tick    = 1'b0;
    i_clk_quarter = 1'b0;
    i_cmd         = {4'h5, 4'hA};
    repeat (2) @(posedge i_clk);
    #1;

    // reset state, then single requester 0
    cyc(0, 2'b00, 0, 0, 2'b00, NOP, 2'b00, 0, 1);
    cyc(1, 2'b01, 0, 0, 2'b00, NOP, 2'b00, 0, 2);
    cyc(1, 2'b01, 1, 0, 2'b01, 4'hA, 2'b01, 0, 3);
    cyc(1, 2'b01, 0, 0, 2'b01, 4'hA, 2'b00, 0, 4);
    cyc(1, 2'b00, 0, 0, 2'b01, 4'hA, 2'b00, 0, 5);
    cyc(1, 2'b00, 1, 0, 2'b00, NOP, 2'b00, 0, 6);
    cyc(1, 2'b00, 0, 0, 2'b00, NOP, 2'b00, 0, 7);

    // simultaneous requests after reset, non-owner slice changes, rotation
    cyc(0, 2'b11, 0, 0, 2'b00, NOP, 2'b00, 0, 8);
    cyc(1, 2'b11, 0, 0, 2'b00, NOP, 2'b00, 0, 9);
    i_cmd = {4'hF, 4'hA};
    cyc(1, 2'b11, 0, 0, 2'b01, 4'hA, 2'b00, 0, 10);
    cyc(1, 2'b10, 1, 0, 2'b01, 4'hA, 2'b01, 0, 11);
    cyc(1, 2'b10, 0, 0, 2'b00, NOP, 2'b00, 0, 12);
    cyc(1, 2'b10, 0, 0, 2'b00, NOP, 2'b00, 0, 13);
    i_cmd = {4'hF, 4'h3};
    cyc(1, 2'b10, 1, 0, 2'b10, 4'hF, 2'b10, 0, 14);
    cyc(1, 2'b00, 0, 0, 2'b10, 4'hF, 2'b00, 0, 15);
    cyc(1, 2'b11, 0, 0, 2'b00, NOP, 2'b00, 0, 16);
    cyc(1, 2'b11, 0, 0, 2'b00, NOP, 2'b00, 0, 17);
    cyc(1, 2'b11, 0, 0, 2'b01, 4'h3, 2'b00, 0, 18);

    // owner 1 mid-transfer, then reset
    cyc(1, 2'b10, 0, 0, 2'b01, 4'h3, 2'b00, 0, 19);
    cyc(1, 2'b10, 0, 0, 2'b00, NOP, 2'b00, 0, 20);
    cyc(1, 2'b10, 0, 0, 2'b00, NOP, 2'b00, 0, 21);
    cyc(1, 2'b10, 0, 0, 2'b10, 4'hF, 2'b00, 0, 22);
    cyc(0, 2'b10, 1, 0, 2'b10, 4'hF, 2'b10, 0, 23);
    cyc(1, 2'b10, 1, 0, 2'b00, NOP, 2'b00, 0, 24);
    cyc(1, 2'b10, 0, 0, 2'b10, 4'hF, 2'b00, 0, 25);
    cyc(1, 2'b00, 0, 0, 2'b10, 4'hF, 2'b00, 0, 26);
    cyc(1, 2'b00, 0, 0, 2'b00, NOP, 2'b00, 0, 27);

`ifdef MOD_BIT_ARB_TIMEOUT_EN
    // stuck owner 0 revoked after 8 quarter strobes, masked until it drops req
    cyc(1, 2'b01, 0, 0, 2'b00, NOP, 2'b00, 0, 30);
    for (int i = 0; i < 8; i++) cyc(1, 2'b11, 0, 1, 2'b01, 4'h3, 2'b00, 0, 31 + i);
    cyc(1, 2'b11, 0, 0, 2'b01, 4'h3, 2'b00, 0, 39);
    cyc(1, 2'b11, 0, 0, 2'b00, NOP, 2'b00, 1, 40);
    cyc(1, 2'b11, 0, 0, 2'b00, NOP, 2'b00, 0, 41);
    cyc(1, 2'b01, 0, 0, 2'b10, 4'hF, 2'b00, 0, 42);
    cyc(1, 2'b01, 0, 0, 2'b00, NOP, 2'b00, 0, 43);
    cyc(1, 2'b01, 0, 0, 2'b00, NOP, 2'b00, 0, 44);
    cyc(1, 2'b00, 0, 0, 2'b00, NOP, 2'b00, 0, 45);
    cyc(1, 2'b01, 0, 0, 2'b00, NOP, 2'b00, 0, 46);
    cyc(1, 2'b01, 0, 0, 2'b01, 4'h3, 2'b00, 0, 47);
`else
    // without the timeout option ownership survives any number of quarter strobes
    cyc(1, 2'b01, 0, 0, 2'b00, NOP, 2'b00, 0, 30);
    for (int i = 0; i < 10; i++) cyc(1, 2'b11, 0, 1, 2'b01, 4'h3, 2'b00, 0, 31 + i);
    cyc(1, 2'b00, 0, 0, 2'b01, 4'h3, 2'b00, 0, 41);
    cyc(1, 2'b00, 0, 0, 2'b00, NOP, 2'b00, 0, 42);
`endif

    repeat (2) @(negedge i_clk);
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want stimulus completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mod_bit_arbiter.md
# mod_bit_arbiter

Round-robin arbiter sharing one `mod_bit` bit-level command engine between up to N command sources (register read/write sequencer, DAA sequencer, IBI handler). Sits between the requesters and `mod_bit`: muxes the granted requester's command onto `o_cmd`, routes `i_cmd_tick` back to the owner only, and drives the idle command whenever no owner exists. Ownership is held for a whole transfer and only changes after an explicit release plus a guard cycle, so a START…STOP sequence is never interleaved.

## Interface

- `N_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT`, 1024: `i_clk_quarter` pulses without `i_cmd_tick` before forced revocation (used only with `MOD_BIT_ARB_TIMEOUT_EN`).
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset_n`  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- `i_clk_quarter`  in  1  one-cycle strobe from `clk_quarter`; timeout counter base.
- `i_req`  in  N_REQ  per-requester bus request, level; held high for the whole transfer.
- `i_cmd`  in  N_REQ*(`MOD_BIT_CMD_WIDTH`+1)  flattened commands, requester k at slice k.
- `o_gnt`  out  N_REQ  one-hot grant (or all zero).
- `o_cmd_tick`  out  N_REQ  `i_cmd_tick` gated to the owner.
- `o_cmd`  out  `MOD_BIT_CMD_WIDTH`+1  command to `mod_bit`.
- `i_cmd_tick`  in  1  command-consumed strobe from `mod_bit`.
- `o_busy`  out  1  high while any grant is active.
- `o_timeout`  out  1  one-cycle pulse on forced revocation (tied 0 without the macro).

## Operation

- States: IDLE, OWNED, GUARD.
- IDLE: if any `i_req` bit high, select first requester starting at `r_last+1` (mod N_REQ) searching upward; register `o_gnt` one-hot, `r_last <= k`, go OWNED. Otherwise stay.
- OWNED: `o_cmd = i_cmd[k]` (combinational mux on registered grant); `o_cmd_tick = {N_REQ{i_cmd_tick}} & o_gnt`. Requests from other sources are ignored. When `i_req[k]` is low, clear `o_gnt`, go GUARD.
- GUARD: one cycle, `o_gnt = 0`, `o_cmd = `MOD_BIT_CMD_NOP_``; then IDLE. Prevents a new owner from seeing the previous owner's final tick.
- Whenever `o_gnt == 0`, `o_cmd` is NOP and `o_cmd_tick` is all zero.
- Non-owner `i_cmd` slices are don't-care; must not influence `o_cmd`.
- `o_busy = |o_gnt`.

## Timing

- Reset values: `o_gnt=0`, `o_cmd_tick=0`, `o_cmd=NOP`, `o_busy=0`, `o_timeout=0`, `r_last=N_REQ-1` (first grant goes to requester 0), state IDLE, counter 0.
- Grant latency: `i_req[k]` high at edge t in IDLE -> `o_gnt[k]` high after edge t+1.
- Release: `i_req[k]` low at edge t -> `o_gnt` low after t+1, GUARD, IDLE after t+2, next grant after t+3 (2 dead cycles of NOP).
- Owner re-asserting `i_req` during GUARD gets no priority; round-robin pointer already advanced past it.
- Simultaneous requests in IDLE: lowest index at or after `r_last+1` wins; wrap-around from N_REQ-1 to 0.
- `i_cmd_tick` coinciding with release edge: still routed to owner (grant still registered that cycle).
- Reset mid-transfer: grant, command and counter return to reset values on the next edge; requesters must restart.

## Configuration

- `MOD_BIT_ARB_TIMEOUT_EN` defined: in OWNED a counter increments on each `i_clk_quarter`, clears on `i_cmd_tick` and on entering OWNED; when it reaches `TIMEOUT`, grant is revoked, `o_timeout` pulses one cycle, state GUARD, and requester k is masked from arbitration until it deasserts `i_req`. Counter width `$clog2(TIMEOUT+1)`.
- Not defined: no counter, no mask; `o_timeout` constant 0; ownership held indefinitely.

## Test plan

- Reset, then `i_req=2'b01` -> `o_gnt=2'b01` one cycle later, `o_cmd` equals slice 0, ticks only on `o_cmd_tick[0]`.
- `i_req=2'b11` simultaneously from IDLE after reset -> grant 0; drop req0 -> 2 NOP cycles, then grant 1; drop req1, re-raise both -> grant 0 (rotation).
- Owner 0 active, req1 raised mid-transfer -> `o_gnt` stays 2'b01 and `o_cmd` unchanged until req0 drops.
- `i_cmd_tick` pulsed while `o_gnt=0` -> `o_cmd_tick=0`, `o_cmd=NOP`.
- `i_reset_n` low while owner 1 mid-transfer -> next edge `o_gnt=0`, `o_cmd=NOP`, `o_busy=0`.
- With `MOD_BIT_ARB_TIMEOUT_EN`, `TIMEOUT=8`: owner holds req, no ticks, 8 `i_clk_quarter` strobes -> `o_timeout` one-cycle pulse, grant removed, req1 granted after GUARD; stuck requester not regranted until it drops req.
